camerax_col_dispatch: RTL and testbench
=======================================

# camerax_col_dispatch

Column scheduler that walks the screen's 320 columns once per frame. For each column it reads the Q8.8 camera-plane X value from the camerax ROM (registered, 1-cycle read latency) and hands the {column, camerax} pair to one of two ray-cast units. Arbitration between the units is round-robin. It sits between the frame timing logic and the ray-cast cores, and is the only master of the ROM address port.

## Interface
Parameters:
- NUM_COLS, 320: columns per frame; the last column is NUM_COLS-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that begins a frame walk. Ignored unless the FSM is in IDLE.
- rom_addr  out  9  registered address to the camerax ROM. Values are only ever 0..NUM_COLS-1.
- rom_data  in  16  camerax ROM output. Valid the cycle after rom_addr is presented. Treated as opaque 16-bit signed Q8.8 and passed through unmodified.
- req  in  2  per-unit request for a column, level-sensitive.
- grant  out  2  one-hot, combinational. A transfer to unit i occurs in any cycle where col_valid and grant[i] are both high.
- col_valid  out  1  the col_idx and col_camerax outputs hold a column that is ready for hand-off.
- col_idx  out  9  column number of the offered column.
- col_camerax  out  16  camerax of the offered column.
- busy  out  1  high from the cycle after frame_start is accepted until frame_done.
- frame_done  out  1  one-cycle pulse the cycle after the last column's transfer.

## Operation
- FSM states: IDLE, FETCH, WAIT, OFFER, DONE.
- IDLE:
  - On frame_start: col counter ← 0, go to FETCH.
- FETCH:
  - rom_addr ← counter (presented this cycle); go to WAIT.
- WAIT:
  - rom_data is valid; latch it into col_camerax and latch the counter into col_idx; go to OFFER.
- OFFER:
  - col_valid = 1. The offered data stays stable until it is transferred.
- Arbitration in OFFER:
  - grant = req masked to a single bit using round-robin priority.
  - The priority pointer resets to unit 0.
  - After a transfer to unit i, unit 1-i gets priority.
  - If only one unit requests, that unit is granted regardless of the pointer.
  - grant is 0 whenever col_valid is 0.
- On a transfer:
  - If the counter equals NUM_COLS-1, go to DONE.
  - Otherwise increment the counter and go to FETCH.
- DONE:
  - frame_done = 1 for this one cycle; go to IDLE.
- frame_start is ignored in every state except IDLE; it is neither queued nor restarted.
- rst in any state, mid-frame included, forces:
  - state = IDLE, counter = 0, pointer = 0;
  - rom_addr = 0, col_idx = 0, col_camerax = 0;
  - col_valid = 0, grant = 0, busy = 0, frame_done = 0.
- Counter width is 9 bits. The counter never wraps because it stops at NUM_COLS-1.

## Timing
- Cycle 0: frame_start sampled in IDLE.
- Cycle 1: FETCH, rom_addr = 0, busy = 1.
- Cycle 2: WAIT.
- Cycle 3: first col_valid.
- Without prefetch, each column takes at least 3 cycles. With req held high, transfers occur at cycles 3, 6, …, 960, and frame_done is at cycle 961.
- A stalled column (no req) holds col_valid indefinitely without data changing; there is no timeout.
- busy falls in the same cycle frame_done is asserted. A new frame_start is accepted in the following cycle, which is IDLE.

## Configuration
- CAMERAX_PREFETCH_EN defined:
  - A second holding register is added.
  - The next column's ROM read is issued while the current column is being offered. This overlaps FETCH and WAIT with OFFER.
  - With req held high, transfers occur every cycle at cycles 3..322, and frame_done is at cycle 323.
  - Data ordering and the arbitration rules are unchanged.
  - rom_addr never exceeds NUM_COLS-1; no prefetch is issued past the last column.
  - On rst, the prefetch register is discarded.
- CAMERAX_PREFETCH_EN undefined:
  - The sequential FSM above applies, with a minimum of 3 cycles per column.

## Test plan
- Single frame, req = 2'b01 held: unit 0 receives col_idx 0..319 in order, with col_camerax equal to the ROM contents at each index. frame_done occurs at cycle 961 (prefetch: 323). rom_addr never exceeds 319.
- req = 2'b11 held: grants alternate 01, 10, 01, … starting with unit 0. Each unit receives exactly 160 columns; unit 0 gets the even columns.
- Backpressure: req = 0 for 50 cycles while col_valid is high. col_idx, col_camerax and col_valid hold stable and grant stays 0. Re-raising req transfers the same column once.
- frame_start pulsed mid-frame at column 100: it is ignored, with no reset of the counter and no extra frame_done. A frame_start pulsed while in IDLE afterwards starts a new walk from column 0.
- rst asserted while offering column 57: next cycle all outputs are 0 and the FSM is IDLE. A subsequent frame_start starts from column 0 with the pointer at unit 0.
- Edge entry: ROM value 16'h8000 at column 319 passes through bit-exact, followed by a frame_done pulse exactly one cycle wide.

Source files
------------

// File: rtl/camerax_col_dispatch_if.sv
// camerax_col_dispatch_if
//   Bundles the camerax ROM read port and the column hand-off to the two
//   ray-cast units.
//   rom_addr    : column address to the camerax ROM (registered)
//   rom_data    : ROM output, valid the cycle after rom_addr is presented
//   req         : per-unit request, level-sensitive
//   grant       : one-hot grant; transfer when col_valid & grant[i]
//   col_valid   : col_idx / col_camerax hold a column ready for hand-off
//   col_idx     : column number on offer
//   col_camerax : Q8.8 camerax of the column on offer
// Modports: master = dispatcher, slave = ROM + ray-cast side.
interface camerax_col_dispatch_if;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        col_valid;
    logic [8:0]  col_idx;
    logic [15:0] col_camerax;

    modport master (
        output rom_addr, grant, col_valid, col_idx, col_camerax,
        input  rom_data, req
    );

    modport slave (
        input  rom_addr, grant, col_valid, col_idx, col_camerax,
        output rom_data, req
    );
endinterface

// File: rtl/camerax_col_dispatch.sv
// camerax_col_dispatch
//   Walks NUM_COLS screen columns once per frame, reads each column's
//   camerax from the ROM and hands {column, camerax} to one of two ray-cast
//   units under round-robin arbitration.
// Ports:
//   clk         : system clock, posedge
//   rst         : synchronous active-high reset
//   frame_start : one-cycle pulse starting a frame walk (IDLE only)
//   bus         : master side of camerax_col_dispatch_if (ROM port + hand-off)
//   busy        : frame walk in progress (low again in the frame_done cycle)
//   frame_done  : one-cycle pulse the cycle after the last column's transfer
// Build option:
//   CAMERAX_PREFETCH_EN : overlap ROM reads with the offer so that a column
//                         can transfer every cycle (adds a holding register).
module camerax_col_dispatch #(
    parameter int unsigned NUM_COLS = 320
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    camerax_col_dispatch_if.master        bus,
    output logic                          busy,
    output logic                          frame_done
);

    localparam logic [8:0] LAST_COL = 9'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        OFFER,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  rom_addr_q;
    logic [8:0]  col_idx_q;
    logic [15:0] col_cam_q;
    logic        ptr_q;
    logic        col_valid;
    logic [1:0]  grant;
    logic        xfer;
    logic        last_xfer;

`ifdef CAMERAX_PREFETCH_EN
    // a_v_q : rom_addr_q carries a live read this cycle
    // d_v_q : rom_data carries the column d_col_q this cycle
    // o_v_q : col_idx_q/col_cam_q hold a column (offer slot)
    // h_*   : holding slot behind the offer slot
    logic        a_v_q, d_v_q, o_v_q, h_v_q;
    logic [8:0]  d_col_q, h_col_q;
    logic [15:0] h_dat_q;
    logic        n_o_v, n_h_v, capture_h, drop;
    logic [8:0]  n_o_col;
    logic [15:0] n_o_dat;
`endif

    assign bus.rom_addr    = rom_addr_q;
    assign bus.col_idx     = col_idx_q;
    assign bus.col_camerax = col_cam_q;
    assign bus.col_valid   = col_valid;
    assign bus.grant       = grant;

    assign xfer      = col_valid & (|grant);
    assign last_xfer = xfer & (col_idx_q == LAST_COL);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) state_d = FETCH;
            end
            FETCH: begin
                busy    = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy    = 1'b1;
                state_d = OFFER;
            end
            OFFER: begin
                busy = 1'b1;
                if (last_xfer) begin
                    state_d = DONE;
                end
`ifndef CAMERAX_PREFETCH_EN
                else if (xfer) begin
                    state_d = FETCH;
                end
`endif
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef CAMERAX_PREFETCH_EN
        col_valid = (state_q == OFFER) && o_v_q;
`else
        col_valid = (state_q == OFFER);
`endif
    end

    // ---------------- round-robin arbitration ----------------
    // ptr_q = 1 gives unit 1 priority when both request.
    always_comb begin
        grant = '0;
        if (col_valid) begin
            case (bus.req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    // After serving unit 0 the other unit gets priority, and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (xfer) begin
            ptr_q <= grant[0];
        end
    end

`ifndef CAMERAX_PREFETCH_EN
    // ---------------- sequential datapath ----------------
    // rom_addr_q doubles as the column counter: it is loaded with the
    // column to fetch on every entry into FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            col_idx_q  <= '0;
            col_cam_q  <= '0;
        end else begin
            if (state_q == IDLE && frame_start) begin
                rom_addr_q <= '0;
            end
            if (state_q == WAIT) begin
                col_idx_q <= rom_addr_q;
                col_cam_q <= bus.rom_data;
            end
            if (xfer && !last_xfer) begin
                rom_addr_q <= rom_addr_q + 9'd1;
            end
        end
    end
`else
    // ---------------- prefetch datapath ----------------
    // Reads are issued every cycle. Arriving ROM data fills the offer slot,
    // else the holding slot; if both are occupied the arriving column is
    // dropped and its address re-issued (the read behind it is squashed),
    // so column order is preserved without a deeper buffer.
    always_comb begin
        n_o_v     = o_v_q;
        n_o_col   = col_idx_q;
        n_o_dat   = col_cam_q;
        n_h_v     = h_v_q;
        capture_h = 1'b0;
        drop      = 1'b0;
        if (xfer) begin
            n_o_v   = h_v_q;
            n_o_col = h_col_q;
            n_o_dat = h_dat_q;
            n_h_v   = 1'b0;
        end
        if (d_v_q) begin
            if (!n_o_v) begin
                n_o_v   = 1'b1;
                n_o_col = d_col_q;
                n_o_dat = bus.rom_data;
            end else if (!n_h_v) begin
                n_h_v     = 1'b1;
                capture_h = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            col_idx_q  <= '0;
            col_cam_q  <= '0;
            a_v_q      <= 1'b0;
            d_v_q      <= 1'b0;
            o_v_q      <= 1'b0;
            h_v_q      <= 1'b0;
            d_col_q    <= '0;
            h_col_q    <= '0;
            h_dat_q    <= '0;
        end else if (state_q == IDLE) begin
            d_v_q <= 1'b0;
            o_v_q <= 1'b0;
            h_v_q <= 1'b0;
            a_v_q <= frame_start;
            if (frame_start) rom_addr_q <= '0;
        end else if (state_q == DONE) begin
            a_v_q <= 1'b0;
            d_v_q <= 1'b0;
            o_v_q <= 1'b0;
            h_v_q <= 1'b0;
        end else begin
            o_v_q     <= n_o_v;
            col_idx_q <= n_o_col;
            col_cam_q <= n_o_dat;
            h_v_q     <= n_h_v;
            if (capture_h) begin
                h_col_q <= d_col_q;
                h_dat_q <= bus.rom_data;
            end
            if (drop) begin
                rom_addr_q <= d_col_q;
                a_v_q      <= 1'b1;
                d_v_q      <= 1'b0;
            end else begin
                d_v_q   <= a_v_q;
                d_col_q <= rom_addr_q;
                // Stop issuing once the last column's address has gone out.
                if (a_v_q && rom_addr_q != LAST_COL) begin
                    rom_addr_q <= rom_addr_q + 9'd1;
                end else begin
                    a_v_q <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_camerax_col_dispatch.sv
module tb_camerax_col_dispatch;

`ifdef CAMERAX_PREFETCH_EN
    localparam int STRIDE   = 1;
    localparam int DONE_CYC = 323;
`else
    localparam int STRIDE   = 3;
    localparam int DONE_CYC = 961;
`endif
    localparam int LIMIT = 1200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic busy, frame_done;
    int   n_checks = 0;
    int   n_fail   = 0;

    camerax_col_dispatch_if bus();

    camerax_col_dispatch #(.NUM_COLS(320)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Reference ROM contents: distinct per column, 0x8000 at the last column.
    function automatic logic [15:0] rom_val(input int i);
        if (i == 319) return 16'h8000;
        return 16'(i * 521 + 3);
    endfunction

    always_ff @(posedge clk) bus.rom_data <= rom_val(int'(bus.rom_addr));

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        bus.req = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.req = 2'b11;
        #1;
        n_checks++; if (bus.rom_addr !== 9'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr); end
        n_checks++; if (bus.col_idx !== 9'd0) begin n_fail++; $display("FAIL reset_col_idx: got %0d want 0", bus.col_idx); end
        n_checks++; if (bus.col_camerax !== 16'h0) begin n_fail++; $display("FAIL reset_camerax: got %h want 0000", bus.col_camerax); end
        n_checks++; if (bus.col_valid !== 1'b0) begin n_fail++; $display("FAIL reset_col_valid: got %b want 0", bus.col_valid); end
        n_checks++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        bus.req = 2'b00;
    endtask

    task automatic test_single_unit();
        int xfers = 0;
        int done_cyc = -1;
        logic [15:0] last_cam = 16'h0;
        do_reset();
        bus.req = 2'b01;
        frame_start = 1'b1;
        for (int j = 1; j <= LIMIT; j++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (j == 1) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL su_busy_c1: got %b want 1", busy); end
                n_checks++; if (bus.rom_addr !== 9'd0) begin n_fail++; $display("FAIL su_rom_addr_c1: got %0d want 0", bus.rom_addr); end
            end
            n_checks++; if (bus.rom_addr > 9'd319) begin n_fail++; $display("FAIL su_rom_addr_range: got %0d want <=319 at cycle %0d", bus.rom_addr, j); end
            if (bus.col_valid === 1'b1 && bus.grant !== 2'b00) begin
                n_checks++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL su_grant: got %b want 01", bus.grant); end
                n_checks++; if (bus.col_idx !== 9'(xfers)) begin n_fail++; $display("FAIL su_col_idx: got %0d want %0d", bus.col_idx, xfers); end
                n_checks++; if (bus.col_camerax !== rom_val(xfers)) begin n_fail++; $display("FAIL su_camerax: got %h want %h col %0d", bus.col_camerax, rom_val(xfers), xfers); end
                n_checks++; if (j != 3 + xfers * STRIDE) begin n_fail++; $display("FAIL su_xfer_cycle: got %0d want %0d", j, 3 + xfers * STRIDE); end
                if (bus.col_idx === 9'd319) last_cam = bus.col_camerax;
                xfers++;
            end
            if (frame_done === 1'b1) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL su_busy_at_done: got %b want 0", busy); end
                done_cyc = j;
                break;
            end
        end
        n_checks++; if (xfers != 320) begin n_fail++; $display("FAIL su_xfer_count: got %0d want 320", xfers); end
        n_checks++; if (done_cyc != DONE_CYC) begin n_fail++; $display("FAIL su_done_cycle: got %0d want %0d", done_cyc, DONE_CYC); end
        n_checks++; if (last_cam !== 16'h8000) begin n_fail++; $display("FAIL su_col319_camerax: got %h want 8000", last_cam); end
        @(posedge clk); #1;
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL su_done_width: got %b want 0", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL su_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int xfers = 0;
        int c0 = 0;
        int c1 = 0;
        int dones = 0;
        do_reset();
        bus.req = 2'b11;
        frame_start = 1'b1;
        for (int j = 1; j <= LIMIT; j++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (bus.col_valid === 1'b1 && bus.grant !== 2'b00) begin
                n_checks++; if (bus.grant !== ((xfers % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_grant: got %b want %b xfer %0d", bus.grant, (xfers % 2 == 0) ? 2'b01 : 2'b10, xfers); end
                n_checks++; if (bus.col_idx !== 9'(xfers)) begin n_fail++; $display("FAIL rr_col_idx: got %0d want %0d", bus.col_idx, xfers); end
                if (bus.grant === 2'b01) c0++;
                if (bus.grant === 2'b10) c1++;
                xfers++;
            end
            if (frame_done === 1'b1) begin
                dones++;
                break;
            end
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL rr_done_seen: got %0d want 1", dones); end
        n_checks++; if (c0 != 160) begin n_fail++; $display("FAIL rr_unit0_count: got %0d want 160", c0); end
        n_checks++; if (c1 != 160) begin n_fail++; $display("FAIL rr_unit1_count: got %0d want 160", c1); end
    endtask

    task automatic test_backpressure();
        int found = 0;
        int next_col = -1;
        do_reset();
        bus.req = 2'b01;
        frame_start = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (bus.col_valid === 1'b1 && bus.col_idx === 9'd5) begin
                bus.req = 2'b00;
                found = 1;
                break;
            end
        end
        n_checks++; if (found != 1) begin n_fail++; $display("FAIL bp_reach_col5: got %0d want 1", found); end
        for (int j = 0; j < 50; j++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.col_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b want 1", bus.col_valid); end
            n_checks++; if (bus.col_idx !== 9'd5) begin n_fail++; $display("FAIL bp_idx_hold: got %0d want 5", bus.col_idx); end
            n_checks++; if (bus.col_camerax !== rom_val(5)) begin n_fail++; $display("FAIL bp_cam_hold: got %h want %h", bus.col_camerax, rom_val(5)); end
            n_checks++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL bp_grant_zero: got %b want 00", bus.grant); end
        end
        bus.req = 2'b01;
        #1;
        n_checks++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL bp_resume_grant: got %b want 01", bus.grant); end
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            if (bus.col_valid === 1'b1 && bus.grant !== 2'b00) begin
                next_col = int'(bus.col_idx);
                break;
            end
        end
        n_checks++; if (next_col != 6) begin n_fail++; $display("FAIL bp_next_col: got %0d want 6", next_col); end
    endtask

    task automatic test_midframe_start();
        int xfers = 0;
        int pulsed = 0;
        int dones = 0;
        int done_cyc = -1;
        int extra = 0;
        int first_cyc = -1;
        int first_col = -1;
        do_reset();
        bus.req = 2'b01;
        frame_start = 1'b1;
        for (int j = 1; j <= LIMIT; j++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (bus.col_valid === 1'b1 && bus.col_idx === 9'd100 && pulsed == 0) begin
                frame_start = 1'b1;
                pulsed = 1;
            end
            if (bus.col_valid === 1'b1 && bus.grant !== 2'b00) begin
                n_checks++; if (bus.col_idx !== 9'(xfers)) begin n_fail++; $display("FAIL mf_col_idx: got %0d want %0d", bus.col_idx, xfers); end
                xfers++;
            end
            if (frame_done === 1'b1) begin
                dones++;
                done_cyc = j;
                break;
            end
        end
        frame_start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++; if (xfers != 320) begin n_fail++; $display("FAIL mf_xfer_count: got %0d want 320", xfers); end
        n_checks++; if (done_cyc != DONE_CYC) begin n_fail++; $display("FAIL mf_done_cycle: got %0d want %0d", done_cyc, DONE_CYC); end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL mf_extra_activity: got %0d want 0", extra); end
        frame_start = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (bus.col_valid === 1'b1 && bus.grant !== 2'b00) begin
                first_cyc = j;
                first_col = int'(bus.col_idx);
                break;
            end
        end
        n_checks++; if (first_col != 0) begin n_fail++; $display("FAIL mf_restart_col: got %0d want 0", first_col); end
        n_checks++; if (first_cyc != 3) begin n_fail++; $display("FAIL mf_restart_cycle: got %0d want 3", first_cyc); end
    endtask

    task automatic test_reset_midframe();
        int found = 0;
        int first_col = -1;
        int first_cyc = -1;
        logic [1:0] first_grant = 2'b00;
        do_reset();
        bus.req = 2'b11;
        frame_start = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (bus.col_valid === 1'b1 && bus.col_idx === 9'd57) begin
                found = 1;
                rst = 1'b1;
                break;
            end
        end
        n_checks++; if (found != 1) begin n_fail++; $display("FAIL rm_reach_col57: got %0d want 1", found); end
        @(posedge clk); #1;
        n_checks++; if (bus.rom_addr !== 9'd0) begin n_fail++; $display("FAIL rm_rom_addr: got %0d want 0", bus.rom_addr); end
        n_checks++; if (bus.col_idx !== 9'd0) begin n_fail++; $display("FAIL rm_col_idx: got %0d want 0", bus.col_idx); end
        n_checks++; if (bus.col_camerax !== 16'h0) begin n_fail++; $display("FAIL rm_camerax: got %h want 0000", bus.col_camerax); end
        n_checks++; if (bus.col_valid !== 1'b0) begin n_fail++; $display("FAIL rm_col_valid: got %b want 0", bus.col_valid); end
        n_checks++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL rm_grant: got %b want 00", bus.grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rm_frame_done: got %b want 0", frame_done); end
        rst = 1'b0;
        frame_start = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (bus.col_valid === 1'b1 && bus.grant !== 2'b00) begin
                first_cyc = j;
                first_col = int'(bus.col_idx);
                first_grant = bus.grant;
                break;
            end
        end
        n_checks++; if (first_col != 0) begin n_fail++; $display("FAIL rm_restart_col: got %0d want 0", first_col); end
        n_checks++; if (first_grant !== 2'b01) begin n_fail++; $display("FAIL rm_restart_grant: got %b want 01", first_grant); end
        n_checks++; if (first_cyc != 3) begin n_fail++; $display("FAIL rm_restart_cycle: got %0d want 3", first_cyc); end
    endtask

    initial begin
        bus.req = 2'b00;
        test_reset();
        test_single_unit();
        test_round_robin();
        test_backpressure();
        test_midframe_start();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
